// File: rtl/filt_mac_pkg.sv
// Shared state encoding and sizing helpers for the filter MAC scheduler.
package filt_mac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } t_state;

    // A symmetric filter folds mirrored taps, so only half (rounded up) are stepped.
    function automatic int f_num_taps(input int len, input int symm);
        return (symm != 0) ? (len + 1) / 2 : len;
    endfunction

    function automatic int f_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/filt_mac_rr_arb.sv
// Channel arbiter: round-robin after the pointer, or fixed lowest-index-first
// priority when FILT_MAC_SCHED_PRIO_EN is defined.
module filt_mac_rr_arb
    import filt_mac_pkg::*;
#(
    parameter int gp_num_ch   = 4,
    parameter int gp_id_width = f_idx_w(gp_num_ch)
) (
    input  logic [gp_num_ch-1:0]   i_req,
    input  logic                   i_ena,
    input  logic [gp_id_width-1:0] i_ptr,
    output logic [gp_num_ch-1:0]   o_grant,
    output logic [gp_id_width-1:0] o_id,
    output logic                   o_any
);

    localparam logic [gp_num_ch-1:0] lp_one = gp_num_ch'(1'b1);

`ifdef FILT_MAC_SCHED_PRIO_EN
    logic w_unused_ptr;
    assign w_unused_ptr = ^i_ptr;

    // Scan from the top down so the lowest requesting index is the last write.
    always_comb begin
        logic v_hit;
        o_grant = '0;
        o_id    = '0;
        o_any   = 1'b0;
        for (int i = gp_num_ch - 1; i >= 0; i--) begin
            v_hit   = i_ena && i_req[i];
            o_any   = o_any | v_hit;
            o_id    = v_hit ? gp_id_width'(i) : o_id;
            o_grant = v_hit ? (lp_one << i) : o_grant;
        end
    end
`else
    // Scan offsets from farthest to nearest so the first requester after i_ptr wins.
    always_comb begin
        logic v_hit;
        int   v_idx;
        o_grant = '0;
        o_id    = '0;
        o_any   = 1'b0;
        for (int off = gp_num_ch; off >= 1; off--) begin
            v_idx   = (int'(i_ptr) + off) % gp_num_ch;
            v_hit   = i_ena && i_req[v_idx];
            o_any   = o_any | v_hit;
            o_id    = v_hit ? gp_id_width'(v_idx) : o_id;
            o_grant = v_hit ? (lp_one << v_idx) : o_grant;
        end
    end
`endif

endmodule

// File: rtl/filt_mac_sched.sv
// Time-shares one MAC datapath across gp_num_ch channels: grant, load, step taps, publish.
// Build option FILT_MAC_SCHED_PRIO_EN selects fixed-priority arbitration.
module filt_mac_sched
    import filt_mac_pkg::*;
#(
    parameter int gp_num_ch       = 4,
    parameter int gp_data_width   = 8,
    parameter int gp_coeff_length = 17,
    parameter int gp_symm         = 1,
    parameter int gp_oup_width    = gp_data_width + 12 + gp_coeff_length
) (
    input  logic                                          i_clk,
    input  logic                                          i_rst,
    input  logic                                          i_ena,
    input  logic [gp_num_ch-1:0]                          i_valid,
    input  logic [gp_num_ch*gp_data_width-1:0]            i_data,
    output logic [gp_num_ch-1:0]                          o_ready,
    output logic                                          o_mac_load,
    output logic                                          o_mac_clr,
    output logic                                          o_mac_acc,
    output logic [f_idx_w(f_num_taps(gp_coeff_length, gp_symm))-1:0] o_mac_tap,
    output logic [f_idx_w(gp_num_ch)-1:0]                 o_mac_ch,
    output logic [gp_data_width-1:0]                      o_mac_data,
    input  logic [gp_oup_width-1:0]                       i_mac_result,
    output logic [gp_oup_width-1:0]                       o_data,
    output logic [f_idx_w(gp_num_ch)-1:0]                 o_ch,
    output logic                                          o_valid
);

    localparam int lp_c     = f_num_taps(gp_coeff_length, gp_symm);
    localparam int lp_tap_w = f_idx_w(lp_c);
    localparam int lp_ch_w  = f_idx_w(gp_num_ch);
    localparam logic [lp_tap_w-1:0] lp_last_tap = lp_tap_w'(lp_c - 1);
    localparam logic [lp_ch_w-1:0]  lp_last_ch  = lp_ch_w'(gp_num_ch - 1);

    t_state                    r_state, w_state_nxt;
    logic [lp_tap_w-1:0]       r_tap, w_tap_nxt;
    logic [lp_ch_w-1:0]        r_last_grant, w_last_grant_nxt;
    logic [gp_num_ch-1:0]      r_ready, w_ready_nxt;
    logic                      r_load, w_load_nxt;
    logic                      r_clr, w_clr_nxt;
    logic                      r_acc, w_acc_nxt;
    logic [lp_ch_w-1:0]        r_mac_ch, w_mac_ch_nxt;
    logic [gp_data_width-1:0]  r_mac_data, w_mac_data_nxt;
    logic [gp_oup_width-1:0]   r_data, w_data_nxt;
    logic [lp_ch_w-1:0]        r_ch, w_ch_nxt;
    logic                      r_valid, w_valid_nxt;

    logic [gp_num_ch-1:0]      w_grant;
    logic [lp_ch_w-1:0]        w_grant_id;
    logic                      w_any;
    logic                      w_arb_ena;
    logic [gp_data_width-1:0]  w_sel_data;

    assign w_arb_ena  = (r_state == ST_IDLE);
    assign w_sel_data = i_data[int'(w_grant_id)*gp_data_width +: gp_data_width];

    filt_mac_rr_arb #(
        .gp_num_ch   (gp_num_ch),
        .gp_id_width (lp_ch_w)
    ) u_arb (
        .i_req   (i_valid),
        .i_ena   (w_arb_ena),
        .i_ptr   (r_last_grant),
        .o_grant (w_grant),
        .o_id    (w_grant_id),
        .o_any   (w_any)
    );

    // Next state and next output values; outputs describe the state being entered.
    always_comb begin
        w_state_nxt      = r_state;
        w_tap_nxt        = r_tap;
        w_last_grant_nxt = r_last_grant;
        w_ready_nxt      = '0;
        w_load_nxt       = 1'b0;
        w_clr_nxt        = 1'b0;
        w_acc_nxt        = 1'b0;
        w_valid_nxt      = 1'b0;
        w_mac_ch_nxt     = r_mac_ch;
        w_mac_data_nxt   = r_mac_data;
        w_data_nxt       = r_data;
        w_ch_nxt         = r_ch;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_state_nxt      = ST_LOAD;
                    w_ready_nxt      = w_grant;
                    w_last_grant_nxt = w_grant_id;
                    w_mac_ch_nxt     = w_grant_id;
                    w_mac_data_nxt   = w_sel_data;
                    w_load_nxt       = 1'b1;
                    w_clr_nxt        = 1'b1;
                    w_tap_nxt        = '0;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_LOAD: begin
                w_state_nxt = ST_RUN;
                w_tap_nxt   = '0;
                w_acc_nxt   = 1'b1;
            end
            ST_RUN: begin
                if (r_tap == lp_last_tap) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_tap_nxt = r_tap + lp_tap_w'(1'b1);
                    w_acc_nxt = 1'b1;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
                w_valid_nxt = 1'b1;
                w_data_nxt  = i_mac_result;
                w_ch_nxt    = r_mac_ch;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and output registers; a disabled cycle freezes everything but drops strobes.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_tap        <= '0;
            r_last_grant <= lp_last_ch;
            r_ready      <= '0;
            r_load       <= 1'b0;
            r_clr        <= 1'b0;
            r_acc        <= 1'b0;
            r_mac_ch     <= '0;
            r_mac_data   <= '0;
            r_data       <= '0;
            r_ch         <= '0;
            r_valid      <= 1'b0;
        end else if (i_ena) begin
            r_state      <= w_state_nxt;
            r_tap        <= w_tap_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_ready      <= w_ready_nxt;
            r_load       <= w_load_nxt;
            r_clr        <= w_clr_nxt;
            r_acc        <= w_acc_nxt;
            r_mac_ch     <= w_mac_ch_nxt;
            r_mac_data   <= w_mac_data_nxt;
            r_data       <= w_data_nxt;
            r_ch         <= w_ch_nxt;
            r_valid      <= w_valid_nxt;
        end else begin
            r_ready <= '0;
            r_load  <= 1'b0;
            r_clr   <= 1'b0;
            r_acc   <= 1'b0;
            r_valid <= 1'b0;
        end
    end

    assign o_ready    = r_ready;
    assign o_mac_load = r_load;
    assign o_mac_clr  = r_clr;
    assign o_mac_acc  = r_acc;
    assign o_mac_tap  = r_tap;
    assign o_mac_ch   = r_mac_ch;
    assign o_mac_data = r_mac_data;
    assign o_data     = r_data;
    assign o_ch       = r_ch;
    assign o_valid    = r_valid;

endmodule
